// File: rtl/decoder3x8_frame.sv
// Registered 3-to-8 decoder that also rebuilds the request vector from a frame of
// descending priority-encoder codes terminated by idle, flagging out-of-order codes.
module decoder3x8_frame #(
   parameter int unsigned CODE_W      = 3,
   parameter bit          CHECK_ORDER = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     in_valid,
   input  logic [CODE_W-1:0]        code,
   input  logic                     idle,
   output logic [(2**CODE_W)-1:0]   onehot,
   output logic [(2**CODE_W)-1:0]   vec,
   output logic                     vec_valid,
   output logic                     order_err,
   output logic [CODE_W:0]          code_cnt
);

   localparam int unsigned OutW = 2**CODE_W;
   localparam int unsigned CntW = CODE_W + 1;

   typedef enum logic [0:0] {
      StWait,
      StCollect
   } state_e;

   state_e              state_q, state_d;
   logic [OutW-1:0]     onehot_q, onehot_d;
   logic [OutW-1:0]     acc_q, acc_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [CODE_W-1:0]   last_q, last_d;
   logic [OutW-1:0]     vec_q, vec_d;
   logic                vec_valid_q, vec_valid_d;
   logic                order_err_q, order_err_d;
   logic [CntW-1:0]     code_cnt_q, code_cnt_d;

   logic                accept;
   logic                data_acc;
   logic                idle_acc;
   logic [OutW-1:0]     code_dec;
   logic                cnt_full;

   assign accept   = en & in_valid;
   assign data_acc = accept & ~idle;
   assign idle_acc = accept & idle;
   assign code_dec = OutW'(1) << code;
   assign cnt_full = (cnt_q == CntW'(OutW));

   always_comb begin
      state_d     = state_q;
      onehot_d    = onehot_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      vec_d       = vec_q;
      vec_valid_d = 1'b0;
      order_err_d = order_err_q;
      code_cnt_d  = code_cnt_q;

      if (data_acc) begin
         onehot_d = code_dec;
      end

      unique case (state_q)
         StWait: begin
            if (data_acc) begin
               acc_d       = code_dec;
               cnt_d       = CntW'(1);
               last_d      = code;
               order_err_d = 1'b0;
               state_d     = StCollect;
            end else if (idle_acc) begin
               // Idle with no preceding codes closes an empty frame.
               vec_d       = '0;
               code_cnt_d  = '0;
               vec_valid_d = 1'b1;
               order_err_d = 1'b0;
            end
         end
         StCollect: begin
            if (!en) begin
               // Abort drops the partial frame; vec keeps the last closed frame.
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StWait;
            end else if (data_acc) begin
               acc_d = acc_q | code_dec;
               if (!cnt_full) begin
                  cnt_d = cnt_q + CntW'(1);
               end
               if (CHECK_ORDER && (code >= last_q)) begin
                  order_err_d = 1'b1;
               end
               last_d = code;
            end else if (idle_acc) begin
               vec_d       = acc_q;
               code_cnt_d  = cnt_q;
               vec_valid_d = 1'b1;
               state_d     = StWait;
            end
         end
         default: state_d = StWait;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StWait;
         onehot_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         last_q      <= '0;
         vec_q       <= '0;
         vec_valid_q <= 1'b0;
         order_err_q <= 1'b0;
         code_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         onehot_q    <= onehot_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         vec_q       <= vec_d;
         vec_valid_q <= vec_valid_d;
         order_err_q <= order_err_d;
         code_cnt_q  <= code_cnt_d;
      end
   end

   assign onehot    = onehot_q;
   assign vec       = vec_q;
   assign vec_valid = vec_valid_q;
   assign order_err = order_err_q;
   assign code_cnt  = code_cnt_q;

endmodule

// File: tb/tb_decoder3x8_frame.sv
// Table-driven bench for decoder3x8_frame: each record's expectations are queued when
// driven and compared one clock later, plus a hand-written mid-frame reset sequence.
module tb_decoder3x8_frame;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       in_valid;
   logic [2:0] code;
   logic       idle;
   logic [7:0] onehot;
   logic [7:0] vec;
   logic       vec_valid;
   logic       order_err;
   logic [3:0] code_cnt;

   decoder3x8_frame #(
      .CODE_W      (3),
      .CHECK_ORDER (1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (in_valid),
      .code      (code),
      .idle      (idle),
      .onehot    (onehot),
      .vec       (vec),
      .vec_valid (vec_valid),
      .order_err (order_err),
      .code_cnt  (code_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       iv;
      logic [2:0] code;
      logic       idle;
      logic [7:0] oh;
      logic       vv;
      logic [7:0] vec;
      logic [3:0] cnt;
      logic       err;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic vec_t mk(input logic e, input logic iv, input logic [2:0] c,
                               input logic i, input logic [7:0] oh, input logic vv,
                               input logic [7:0] v, input logic [3:0] n, input logic er);
      vec_t r;
      r.en = e; r.iv = iv; r.code = c; r.idle = i;
      r.oh = oh; r.vv = vv; r.vec = v; r.cnt = n; r.err = er;
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input logic [7:0] act,
                      input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s step %0d: got %02h expected %02h", name, idx, act, exp);
   endtask

   task automatic check_out(input int idx, input vec_t e);
      chk("onehot", idx, onehot, e.oh);
      chk("vec_valid", idx, {7'd0, vec_valid}, {7'd0, e.vv});
      chk("vec", idx, vec, e.vec);
      chk("code_cnt", idx, {4'd0, code_cnt}, {4'd0, e.cnt});
      chk("order_err", idx, {7'd0, order_err}, {7'd0, e.err});
   endtask

   // Compare the previous record's expectation, then drive the next one.
   task automatic step(input int idx, input vec_t r);
      vec_t e;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_out(idx, e);
      end
      en = r.en; in_valid = r.iv; code = r.code; idle = r.idle;
      sb.push_back(r);
   endtask

   task automatic flush(input int idx);
      vec_t e;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_out(idx, e);
      end
      in_valid = 1'b0; idle = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; code = 3'd0; idle = 1'b0;

      // Codes 0..7 ascending in one frame, a 9th repeat, then close.
      tbl.push_back(mk(1, 1, 3'd0, 0, 8'h01, 0, 8'h00, 4'd0, 0));
      for (int c = 1; c < 8; c++)
         tbl.push_back(mk(1, 1, 3'(c), 0, 8'(1 << c), 0, 8'h00, 4'd0, 1));
      tbl.push_back(mk(1, 1, 3'd7, 0, 8'h80, 0, 8'h00, 4'd0, 1));
      tbl.push_back(mk(1, 1, 3'd0, 1, 8'h80, 1, 8'hFF, 4'd8, 1));
      // 7,4,1 frame.
      tbl.push_back(mk(1, 1, 3'd7, 0, 8'h80, 0, 8'hFF, 4'd8, 0));
      tbl.push_back(mk(1, 1, 3'd4, 0, 8'h10, 0, 8'hFF, 4'd8, 0));
      tbl.push_back(mk(1, 1, 3'd1, 0, 8'h02, 0, 8'hFF, 4'd8, 0));
      tbl.push_back(mk(1, 1, 3'd0, 1, 8'h02, 1, 8'h92, 4'd3, 0));
      // Empty frame back-to-back.
      tbl.push_back(mk(1, 1, 3'd0, 1, 8'h02, 1, 8'h00, 4'd0, 0));
      // Order error 3,5 then clean frame 6.
      tbl.push_back(mk(1, 1, 3'd3, 0, 8'h08, 0, 8'h00, 4'd0, 0));
      tbl.push_back(mk(1, 1, 3'd5, 0, 8'h20, 0, 8'h00, 4'd0, 1));
      tbl.push_back(mk(1, 1, 3'd0, 1, 8'h20, 1, 8'h28, 4'd2, 1));
      tbl.push_back(mk(1, 1, 3'd6, 0, 8'h40, 0, 8'h28, 4'd2, 0));
      tbl.push_back(mk(1, 1, 3'd0, 1, 8'h40, 1, 8'h40, 4'd1, 0));
      // Abort with gap, then verify the aborted codes were discarded.
      tbl.push_back(mk(1, 1, 3'd7, 0, 8'h80, 0, 8'h40, 4'd1, 0));
      tbl.push_back(mk(1, 0, 3'd1, 0, 8'h80, 0, 8'h40, 4'd1, 0));
      tbl.push_back(mk(1, 1, 3'd6, 0, 8'h40, 0, 8'h40, 4'd1, 0));
      tbl.push_back(mk(0, 1, 3'd0, 1, 8'h40, 0, 8'h40, 4'd1, 0));
      tbl.push_back(mk(0, 1, 3'd5, 0, 8'h40, 0, 8'h40, 4'd1, 0));
      tbl.push_back(mk(1, 1, 3'd2, 0, 8'h04, 0, 8'h40, 4'd1, 0));
      tbl.push_back(mk(1, 1, 3'd0, 1, 8'h04, 1, 8'h04, 4'd1, 0));
      // Gaps (including an unaccepted idle) inside a frame.
      tbl.push_back(mk(1, 1, 3'd5, 0, 8'h20, 0, 8'h04, 4'd1, 0));
      tbl.push_back(mk(1, 0, 3'd0, 1, 8'h20, 0, 8'h04, 4'd1, 0));
      tbl.push_back(mk(1, 0, 3'd3, 0, 8'h20, 0, 8'h04, 4'd1, 0));
      tbl.push_back(mk(1, 1, 3'd3, 0, 8'h08, 0, 8'h04, 4'd1, 0));
      tbl.push_back(mk(1, 1, 3'd0, 1, 8'h08, 1, 8'h28, 4'd2, 0));
      tbl.push_back(mk(1, 0, 3'd0, 0, 8'h08, 0, 8'h28, 4'd2, 0));

      #12;
      chk("rst_onehot", -1, onehot, 8'h00);
      chk("rst_vec", -1, vec, 8'h00);
      chk("rst_vec_valid", -1, {7'd0, vec_valid}, 8'h00);
      chk("rst_order_err", -1, {7'd0, order_err}, 8'h00);
      chk("rst_code_cnt", -1, {4'd0, code_cnt}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);
      flush(tbl.size());

      // Mid-frame reset with order_err set: everything clears without a clock edge.
      step(100, mk(1, 1, 3'd2, 0, 8'h04, 0, 8'h28, 4'd2, 0));
      step(101, mk(1, 1, 3'd5, 0, 8'h20, 0, 8'h28, 4'd2, 1));
      flush(102);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_onehot", 103, onehot, 8'h00);
      chk("midrst_vec", 103, vec, 8'h00);
      chk("midrst_vec_valid", 103, {7'd0, vec_valid}, 8'h00);
      chk("midrst_order_err", 103, {7'd0, order_err}, 8'h00);
      chk("midrst_code_cnt", 103, {4'd0, code_cnt}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      step(104, mk(1, 1, 3'd3, 0, 8'h08, 0, 8'h00, 4'd0, 0));
      step(105, mk(1, 1, 3'd0, 1, 8'h08, 1, 8'h08, 4'd1, 0));
      flush(106);
      @(negedge clk);
      chk("post_vv_low", 107, {7'd0, vec_valid}, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
